// File: rtl/parity_pkg.sv
// Shared types and defaults for the parity frame sequencer.
package parity_pkg;

    localparam int STATE_W       = 2;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ERR_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

endpackage

// File: rtl/parity_calc.sv
// Combinational even-parity check over a data word plus its parity bit.
module parity_calc #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              par_in,
    output logic              pec
);

    function automatic logic even_parity_err(input logic [DATA_W:0] v);
        return ^v;
    endfunction

    // XOR-reduce data and parity; a set result flags a parity error
    always_comb begin
        pec = even_parity_err({par_in, data_in});
    end

endmodule

// File: rtl/parity_frame_sequencer.sv
// Serial receive sequencer: start, DATA_W data bits LSB first, even parity, stop.
// Optional macro STOP_CHECK_EN adds the ferr framing-error output.
module parity_frame_sequencer
    import parity_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 serial_in,
    input  logic                 clr_cnt,
    output logic [DATA_W-1:0]    data_out,
    output logic                 p_out,
    output logic                 pec,
`ifdef STOP_CHECK_EN
    output logic                 ferr,
`endif
    output logic                 frame_valid,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic                   p_out_q, p_out_d;
    logic                   pec_q, pec_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   busy_q, busy_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   err_inc_s;
    logic                   pec_s;
`ifdef STOP_CHECK_EN
    logic                   ferr_q, ferr_d;
`endif

    parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
        .data_in (shift_q),
        .par_in  (par_q),
        .pec     (pec_s)
    );

    // Next-state, shift datapath and frame-completion outputs
    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        data_out_d    = data_out_q;
        p_out_d       = p_out_q;
        pec_d         = pec_q;
        frame_valid_d = 1'b0;
        err_inc_s     = 1'b0;
`ifdef STOP_CHECK_EN
        ferr_d        = ferr_q;
`endif
        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!serial_in) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d[bit_idx_q] = serial_in;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    par_d   = serial_in;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    data_out_d    = shift_q;
                    p_out_d       = par_q;
                    pec_d         = pec_s;
                    frame_valid_d = 1'b1;
                    state_d       = ST_IDLE;
`ifdef STOP_CHECK_EN
                    // A framing error suppresses the parity-error count
                    ferr_d    = ~serial_in;
                    err_inc_s = pec_s & serial_in;
`else
                    err_inc_s = pec_s;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Saturating error counter; clear has priority over increment
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc_s && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            data_out_q    <= '0;
            p_out_q       <= 1'b0;
            pec_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_cnt_q     <= '0;
`ifdef STOP_CHECK_EN
            ferr_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            data_out_q    <= data_out_d;
            p_out_q       <= p_out_d;
            pec_q         <= pec_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            err_cnt_q     <= err_cnt_d;
`ifdef STOP_CHECK_EN
            ferr_q        <= ferr_d;
`endif
        end
    end

    assign data_out    = data_out_q;
    assign p_out       = p_out_q;
    assign pec         = pec_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign err_cnt     = err_cnt_q;
`ifdef STOP_CHECK_EN
    assign ferr        = ferr_q;
`endif

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// Scoreboard bench for parity_frame_sequencer (DATA_W=4, ERR_CNT_W=8).
module tb_parity_frame_sequencer;

    localparam int DW = 4;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_en;
    logic          serial_in;
    logic          clr_cnt;
    logic [DW-1:0] data_out;
    logic          p_out;
    logic          pec;
    logic          frame_valid;
    logic          busy;
    logic [EW-1:0] err_cnt;
`ifdef STOP_CHECK_EN
    logic          ferr;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          p;
        logic          pec;
        logic [EW-1:0] err;
        logic          ferr;
    } exp_t;

    exp_t    sb[$];
    exp_t    mon_e;
    int      vectors = 0;
    int      miscompares = 0;
    int      gap = 1;
    int      model_err = 0;

    parity_frame_sequencer #(.DATA_W(DW), .ERR_CNT_W(EW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .serial_in   (serial_in),
        .clr_cnt     (clr_cnt),
        .data_out    (data_out),
        .p_out       (p_out),
        .pec         (pec),
`ifdef STOP_CHECK_EN
        .ferr        (ferr),
`endif
        .frame_valid (frame_valid),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare every frame_valid pulse against the oldest expected frame
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_fv", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e.data));
                chk("p_out", 32'(p_out), 32'(mon_e.p));
                chk("pec", 32'(pec), 32'(mon_e.pec));
                chk("err_cnt", 32'(err_cnt), 32'(mon_e.err));
`ifdef STOP_CHECK_EN
                chk("ferr", 32'(ferr), 32'(mon_e.ferr));
`endif
            end
        end
    end

    task automatic send_bit(input logic b, input logic clr);
        serial_in = b;
        bit_en    = 1'b1;
        clr_cnt   = clr;
        @(posedge clk); #1;
        bit_en    = 1'b0;
        clr_cnt   = 1'b0;
        serial_in = 1'b1;
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop, input logic clr);
        exp_t e;
        logic mp;
        logic fe;
        send_bit(1'b0, 1'b0);
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < DW; i++) send_bit(d[i], 1'b0);
        send_bit(p, 1'b0);
        mp = p;
        for (int i = 0; i < DW; i++) mp = mp ^ d[i];
`ifdef STOP_CHECK_EN
        fe = ~stop;
`else
        fe = 1'b0;
`endif
        if (clr) model_err = 0;
        else if (mp && !fe && model_err < 255) model_err++;
        e.data = d; e.p = p; e.pec = mp; e.err = EW'(model_err); e.ferr = fe;
        sb.push_back(e);
        send_bit(stop, clr);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bit_en = 1'b1; serial_in = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; bit_en = 1'b0;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_p", 32'(p_out), 32'd0);
        chk("rst_pec", 32'(pec), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        repeat (20) send_bit(1'b1, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Good frame, then bad parity frames until saturation (back-to-back)
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_good");
        chk("good_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 256; k++) send_frame(4'b0111, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_sat");
        chk("err_sat", 32'(err_cnt), 32'hFF);

        // clr_cnt without a strobe still clears
        clr_cnt = 1'b1; @(posedge clk); #1; clr_cnt = 1'b0;
        model_err = 0;
        chk("clr_idle", 32'(err_cnt), 32'd0);

        // Clear coinciding with an error increment
        for (int k = 0; k < 3; k++) send_frame(4'b0001, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_pre_clr");
        chk("err_three", 32'(err_cnt), 32'd3);
        send_frame(4'b1011, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_clr");
        chk("err_after_clr", 32'(err_cnt), 32'd0);

        // Sparse strobe with reset mid-frame
        gap = 4;
        send_frame(4'b0010, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        model_err = 0;
        wait_drain("drain_mid_rst");
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        repeat (20) begin
            @(posedge clk); #1;
        end
        send_frame(4'b1111, 1'b0, 1'b1, 1'b0);
        send_frame(4'b1100, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_sparse");
        gap = 1;

`ifdef STOP_CHECK_EN
        send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0111, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_ferr");
        chk("ferr_clear", 32'(ferr), 32'd0);
`else
        send_frame(4'b0111, 1'b0, 1'b0, 1'b0);
        wait_drain("drain_nostop");
`endif
        chk("final_err", 32'(err_cnt), 32'(model_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
